ow_rx_responder: RTL and testbench

- Receive side of a single-wire, open-drain, wired-AND serial link. The line idles high through a pullup; the remote transmitter signals by pulling it low.
- Decodes low-pulse widths into bits, assembles LSB-first bytes and presents them on a valid/ready stream.
- Answers a bus-reset pulse with a presence pulse, driven through an open-drain pull-down enable.
- Sits between the pad-level tristate/pull primitives and the byte-level consumer logic.

---
 rtl/ow_pkg.sv | 49 ++++
 rtl/ow_sync_edge.sv | 38 +++
 rtl/ow_rx_responder.sv | 185 ++++++++++++++++++
 tb/tb_ow_rx_responder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ow_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ow_pkg
// Brief   : Shared FSM/symbol types and pulse-width classifier for ow_rx_responder
// Revision: 1.0
// ============================================================================
package ow_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOW        = 2'd1,
        PRES_GAP   = 2'd2,
        PRES_DRIVE = 2'd3
    } ow_state_e;

    typedef enum logic [2:0] {
        SYM_GLITCH = 3'd0,
        SYM_ONE    = 3'd1,
        SYM_ZERO   = 3'd2,
        SYM_FERR   = 3'd3,
        SYM_RESET  = 3'd4
    } ow_sym_e;

    // Cycles from a pad change to the matching edge strobe being consumed.
    localparam int unsigned SYNC_LAT = 3;

    function automatic ow_sym_e classify(
        input int unsigned cnt,
        input int unsigned t_glitch,
        input int unsigned t_one_max,
        input int unsigned t_zero_max,
        input int unsigned t_reset_min
    );
        ow_sym_e sym;
        if (cnt < t_glitch)
            sym = SYM_GLITCH;
        else if (cnt <= t_one_max)
            sym = SYM_ONE;
        else if (cnt <= t_zero_max)
            sym = SYM_ZERO;
        else if (cnt < t_reset_min)
            sym = SYM_FERR;
        else
            sym = SYM_RESET;
        return sym;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ow_sync_edge.sv
`default_nettype none
// ============================================================================
// Module  : ow_sync_edge
// Brief   : Two-flop synchronizer on the bus line plus a one-flop edge detector
// Revision: 1.0
// ============================================================================
module ow_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic line_s,
    output logic fall,
    output logic rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Idle-high bus: all stages reset to 1 so release of reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= line_i;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign line_s = r_sync;
    assign fall   = r_prev & ~r_sync;
    assign rise   = ~r_prev & r_sync;

endmodule
`default_nettype wire

// File: rtl/ow_rx_responder.sv
`default_nettype none
// ============================================================================
// Module  : ow_rx_responder
// Brief   : Single-wire receiver: pulse-width bit decode, LSB-first byte stream,
//           presence response to bus reset via open-drain pull-down enable
// Revision: 1.0
// ============================================================================
module ow_rx_responder
    import ow_pkg::*;
#(
    parameter int          CNT_W       = 10,
    parameter int unsigned T_GLITCH    = 2,
    parameter int unsigned T_ONE_MAX   = 15,
    parameter int unsigned T_ZERO_MAX  = 120,
    parameter int unsigned T_RESET_MIN = 480,
    parameter int unsigned PRES_GAP    = 30,
    parameter int unsigned PRES_LEN    = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       line_i,
    output logic       pull_o,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       ovf_o,
    output logic       ferr_o,
    output logic       bus_reset_o
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam int unsigned      C_TMR_MAX = (PRES_GAP > PRES_LEN) ? PRES_GAP : PRES_LEN;
    localparam int               C_TMR_W   = $clog2(C_TMR_MAX + 1);

    logic                w_line_s;
    logic                w_fall;
    logic                w_rise;

    ow_state_e           r_state;
    ow_state_e           w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [C_TMR_W-1:0]  r_tmr;
    logic [C_TMR_W-1:0]  w_tmr_nxt;
    logic [1:0]          r_blank;
    logic [1:0]          w_blank_nxt;
    logic [2:0]          r_bitcnt;
    logic [2:0]          w_bitcnt_nxt;
    logic [7:0]          r_shift;
    logic [7:0]          w_shift_nxt;
    logic [7:0]          w_byte;
    logic                w_byte_done;
    logic                w_ferr;
    logic                w_brst;
    ow_sym_e             w_sym;

    ow_sync_edge u_sync_edge (
        .clk    (clk),
        .rst    (rst),
        .line_i (line_i),
        .line_s (w_line_s),
        .fall   (w_fall),
        .rise   (w_rise)
    );

    assign w_sym  = classify(32'(r_cnt), T_GLITCH, T_ONE_MAX, T_ZERO_MAX, T_RESET_MIN);
    assign pull_o = (r_state == PRES_DRIVE);

    always_comb begin
        w_state_nxt  = r_state;
        w_tmr_nxt    = r_tmr;
        w_blank_nxt  = r_blank;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_byte       = {(w_sym == SYM_ONE), r_shift[7:1]};
        w_byte_done  = 1'b0;
        w_ferr       = 1'b0;
        w_brst       = 1'b0;

        case (r_state)
            IDLE: begin
                // Edges caused by our own presence drive are still in the synchronizer.
                if (r_blank != 2'd0)
                    w_blank_nxt = r_blank - 2'd1;
                else if (w_fall)
                    w_state_nxt = LOW;
            end

            LOW: begin
                if (w_rise) begin
                    w_state_nxt = IDLE;
                    case (w_sym)
                        SYM_ONE, SYM_ZERO: begin
                            if (r_bitcnt == 3'd7) begin
                                w_byte_done  = 1'b1;
                                w_bitcnt_nxt = 3'd0;
                                w_shift_nxt  = 8'h00;
                            end else begin
                                w_bitcnt_nxt = r_bitcnt + 3'd1;
                                w_shift_nxt  = w_byte;
                            end
                        end
                        SYM_FERR: begin
                            w_ferr       = 1'b1;
                            w_bitcnt_nxt = 3'd0;
                            w_shift_nxt  = 8'h00;
                        end
                        SYM_RESET: begin
                            w_brst       = 1'b1;
                            w_bitcnt_nxt = 3'd0;
                            w_shift_nxt  = 8'h00;
                            w_tmr_nxt    = '0;
                            w_state_nxt  = ow_pkg::PRES_GAP;
                        end
                        default: ;
                    endcase
                end
            end

            ow_pkg::PRES_GAP: begin
                if (r_tmr == C_TMR_W'(PRES_GAP - 1)) begin
                    w_tmr_nxt   = '0;
                    w_state_nxt = PRES_DRIVE;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end

            PRES_DRIVE: begin
                if (r_tmr == C_TMR_W'(PRES_LEN - 1)) begin
                    w_tmr_nxt   = '0;
                    w_blank_nxt = 2'(SYNC_LAT);
                    w_state_nxt = IDLE;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end

            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_tmr       <= '0;
            r_blank     <= 2'd0;
            r_bitcnt    <= 3'd0;
            r_shift     <= 8'h00;
            data_o      <= 8'h00;
            valid_o     <= 1'b0;
            ovf_o       <= 1'b0;
            ferr_o      <= 1'b0;
            bus_reset_o <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tmr       <= w_tmr_nxt;
            r_blank     <= w_blank_nxt;
            r_bitcnt    <= w_bitcnt_nxt;
            r_shift     <= w_shift_nxt;
            ferr_o      <= w_ferr;
            bus_reset_o <= w_brst;
            ovf_o       <= 1'b0;

            // The fall cycle is itself low, so the count equals the pulse length.
            if (w_fall)
                r_cnt <= CNT_W'(1);
            else if (!w_line_s && (r_cnt != C_CNT_MAX))
                r_cnt <= r_cnt + 1'b1;

            if (w_byte_done) begin
                if (valid_o && !ready_i) begin
                    ovf_o <= 1'b1;
                end else begin
                    data_o  <= w_byte;
                    valid_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ow_rx_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_ow_rx_responder
// Brief   : Directed vector and sequence bench for ow_rx_responder
// Revision: 1.0
// ============================================================================
module tb_ow_rx_responder;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       ready   = 1'b1;
    logic       low_drv = 1'b0;
    logic       pull;
    logic [7:0] data;
    logic       valid;
    logic       ovf;
    logic       ferr;
    logic       brst;
    wire        line_w;

    // Wired-AND bus: either the remote end or the DUT can pull it low.
    assign line_w = ~(low_drv | pull);

    always #5 clk = ~clk;

    ow_rx_responder dut (
        .clk         (clk),
        .rst         (rst),
        .line_i      (line_w),
        .pull_o      (pull),
        .data_o      (data),
        .valid_o     (valid),
        .ready_i     (ready),
        .ovf_o       (ovf),
        .ferr_o      (ferr),
        .bus_reset_o (brst)
    );

    int         errors = 0;
    int         checks = 0;
    int         nacc   = 0;
    int         vcyc   = 0;
    int         novf   = 0;
    int         nferr  = 0;
    int         nbrst  = 0;
    logic [7:0] last_data = 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid) vcyc++;
            if (valid && ready) begin
                nacc++;
                last_data = data;
            end
            if (ovf)  novf++;
            if (ferr) nferr++;
            if (brst) nbrst++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int w);
        low_drv = 1'b1;
        repeat (w) tick();
        low_drv = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int w1, input int w0);
        pulse(b ? w1 : w0);
        repeat (20) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input int w1, input int w0);
        for (int i = 0; i < 8; i++) send_bit(b[i], w1, w0);
    endtask

    typedef struct {
        logic [7:0] tx;
        int         w1;
        int         w0;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a0, v0, e0, o0, f0, b0, k;
        logic [7:0] b22;

        vecs[0] = '{8'hA5,  8,  60, 8'hA5};
        vecs[1] = '{8'h5A,  2,  16, 8'h5A};
        vecs[2] = '{8'hC3, 15, 120, 8'hC3};
        vecs[3] = '{8'h00,  8, 100, 8'h00};
        vecs[4] = '{8'hFF, 10,  60, 8'hFF};

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset pull_o",      pull,  0);
        check("reset data_o",      data,  8'h00);
        check("reset valid_o",     valid, 0);
        check("reset ovf_o",       ovf,   0);
        check("reset ferr_o",      ferr,  0);
        check("reset bus_reset_o", brst,  0);
        repeat (5) tick();

        // Byte vectors with ready held high
        for (int r = 0; r < 5; r++) begin
            a0 = nacc; v0 = vcyc; e0 = novf + nferr + nbrst;
            send_byte(vecs[r].tx, vecs[r].w1, vecs[r].w0);
            check($sformatf("vec%0d accepted", r), nacc - a0, 1);
            check($sformatf("vec%0d data", r), last_data, vecs[r].exp);
            check($sformatf("vec%0d valid cycles", r), vcyc - v0, 1);
            check($sformatf("vec%0d error pulses", r), novf + nferr + nbrst - e0, 0);
        end

        // Bus reset and presence response
        a0 = nacc; f0 = nferr; b0 = nbrst;
        pulse(500);
        k = 0;
        do begin tick(); k++; end while (!brst && k < 20);
        check("bus_reset latency", k, 3);
        k = 0;
        while (!pull && k < 100) begin tick(); k++; end
        check("presence gap", k, 30);
        k = 0;
        while (pull && k < 300) begin k++; tick(); end
        check("presence length", k, 120);
        repeat (20) tick();
        check("bus_reset pulses", nbrst - b0, 1);
        check("bus_reset no ferr", nferr - f0, 0);
        check("bus_reset no byte", nacc - a0, 0);

        // Overflow with a stalled consumer
        ready = 1'b0;
        a0 = nacc;
        send_byte(8'h3C, 8, 60);
        check("stall valid", valid, 1);
        check("stall data", data, 8'h3C);
        o0 = novf;
        for (int i = 0; i < 7; i++) send_bit(1'b1, 8, 60);
        pulse(8);
        repeat (3) tick();
        check("ovf at 8th bit", ovf, 1);
        tick();
        check("ovf one cycle", ovf, 0);
        repeat (16) tick();
        check("ovf count", novf - o0, 1);
        check("ovf data kept", data, 8'h3C);
        check("ovf valid kept", valid, 1);
        ready = 1'b1;
        tick();
        check("drain valid", valid, 0);
        check("drain data", last_data, 8'h3C);
        check("drain accepted", nacc - a0, 1);

        // Glitch, framing error, then clean bytes
        a0 = nacc; f0 = nferr;
        send_bit(1'b1, 8, 60);
        send_bit(1'b0, 8, 60);
        send_bit(1'b1, 8, 60);
        pulse(1);
        repeat (20) tick();
        check("glitch no ferr", nferr - f0, 0);
        pulse(200);
        repeat (20) tick();
        check("ferr count", nferr - f0, 1);
        check("ferr no byte", nacc - a0, 0);
        send_byte(8'h81, 8, 60);
        check("after ferr data", last_data, 8'h81);
        check("after ferr accepted", nacc - a0, 1);
        for (int i = 0; i < 4; i++) send_bit(i[0] ^ i[1], 8, 60);
        pulse(1);
        repeat (20) tick();
        for (int i = 0; i < 4; i++) send_bit(~(i[0] ^ i[1]), 8, 60);
        check("glitch mid-byte data", last_data, 8'h96);

        // Pending byte survives bus reset; rst mid-presence clears everything
        ready = 1'b0;
        send_byte(8'hE7, 8, 60);
        pulse(500);
        k = 0;
        while (!brst && k < 20) begin tick(); k++; end
        check("pending across bus reset valid", valid, 1);
        check("pending across bus reset data", data, 8'hE7);
        k = 0;
        while (!pull && k < 100) begin tick(); k++; end
        repeat (49) tick();
        check("drive cycle 50 pull_o", pull, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst pull_o",      pull,  0);
        check("rst valid_o",     valid, 0);
        check("rst data_o",      data,  8'h00);
        check("rst ovf_o",       ovf,   0);
        check("rst ferr_o",      ferr,  0);
        check("rst bus_reset_o", brst,  0);
        ready = 1'b1;
        repeat (10) tick();
        a0 = nacc;
        send_byte(8'h5A, 8, 60);
        check("post-rst data", last_data, 8'h5A);
        check("post-rst accepted", nacc - a0, 1);

        // Byte completion coinciding with handshake of the previous byte
        ready = 1'b0;
        send_byte(8'h11, 8, 60);
        check("first byte pending", data, 8'h11);
        a0 = nacc; o0 = novf;
        b22 = 8'h22;
        for (int i = 0; i < 7; i++) send_bit(b22[i], 8, 60);
        pulse(60);
        tick();
        tick();
        ready = 1'b1;
        tick();
        check("coincide valid", valid, 1);
        check("coincide data", data, 8'h22);
        check("coincide accepted first", last_data, 8'h11);
        tick();
        check("coincide second drained", valid, 0);
        check("coincide second data", last_data, 8'h22);
        check("coincide accepted", nacc - a0, 2);
        check("coincide no ovf", novf - o0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
